// File: rtl/perf_counter_bank.sv
// =============================================================================
// Module   : perf_counter_bank
// Brief    : Bank of NUM_CH event counters with sticky overflow, atomic
//            snapshot and a manual / auto-scan registered read port.
//            Optional macro PERF_SATURATE_EN: saturate instead of wrapping.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module perf_counter_bank #(
    parameter int NUM_CH   = 5,
    parameter int CNT_W    = 32,
    parameter int SEL_W    = 3,
    parameter int SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] events,
    input  logic              en,
    input  logic              clr,
    input  logic              snap,
    input  logic              auto_scan,
    input  logic [SEL_W-1:0]  sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [SEL_W-1:0]  rd_ch,
    output logic [NUM_CH-1:0] ovf,
    output logic              snap_valid
);

    localparam int                NUM_SRC    = 2 ** SEL_W;
    localparam int                DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SEL_W-1:0]  c_LAST_CH  = SEL_W'(NUM_CH - 1);
    localparam logic [DIV_W-1:0]  c_DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [0:0] {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    logic [CNT_W-1:0]  r_cnt    [NUM_CH];
    logic [CNT_W-1:0]  r_shadow [NUM_CH];
    logic [NUM_CH-1:0] r_ovf;
    logic              r_snap_valid;

    state_t            r_state, w_state_nxt;
    logic [SEL_W-1:0]  r_scan_idx, w_scan_idx_nxt;
    logic [DIV_W-1:0]  r_div, w_div_nxt;

    logic [SEL_W-1:0]  w_ch;
    logic [CNT_W-1:0]  w_src [NUM_SRC];
    logic [CNT_W-1:0]  r_rd_data;
    logic [SEL_W-1:0]  r_rd_ch;

    // ------------------------------------------------------------------
    // Counters, overflow flags and shadows: rst > clr > snap > increment
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]    <= '0;
                r_shadow[i] <= '0;
            end
            r_ovf        <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            if (snap) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_shadow[i] <= r_cnt[i];
                end
                r_snap_valid <= 1'b1;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (en && events[i]) begin
`ifdef PERF_SATURATE_EN
                    if (&r_cnt[i]) begin
                        r_ovf[i] <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
`else
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                    if (&r_cnt[i]) begin
                        r_ovf[i] <= 1'b1;
                    end
`endif
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Display channel FSM; the divider runs regardless of en
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_MANUAL;
            r_scan_idx <= '0;
            r_div      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_scan_idx <= w_scan_idx_nxt;
            r_div      <= w_div_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_scan_idx_nxt = r_scan_idx;
        w_div_nxt      = r_div;
        case (r_state)
            ST_MANUAL: begin
                if (auto_scan) begin
                    w_state_nxt    = ST_SCAN;
                    w_scan_idx_nxt = '0;
                    w_div_nxt      = '0;
                end
            end
            ST_SCAN: begin
                if (!auto_scan) begin
                    w_state_nxt = ST_MANUAL;
                end else if (r_div == c_DIV_LAST) begin
                    w_div_nxt      = '0;
                    w_scan_idx_nxt = (r_scan_idx == c_LAST_CH) ? '0 : r_scan_idx + 1'b1;
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_MANUAL;
            end
        endcase
    end

    assign w_ch = (r_state == ST_SCAN) ? r_scan_idx : sel;

    // Read sources padded to the full select range so unused channels read 0
    generate
        for (genvar j = 0; j < NUM_SRC; j++) begin : g_rd_src
            if (j < NUM_CH) begin : g_live
                assign w_src[j] = r_snap_valid ? r_shadow[j] : r_cnt[j];
            end else begin : g_empty
                assign w_src[j] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
            r_rd_ch   <= '0;
        end else begin
            r_rd_data <= w_src[w_ch];
            r_rd_ch   <= w_ch;
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_ch      = r_rd_ch;
    assign ovf        = r_ovf;
    assign snap_valid = r_snap_valid;

endmodule

`default_nettype wire

// File: tb/tb_perf_counter_bank.sv
// =============================================================================
// Module   : tb_perf_counter_bank
// Brief    : Directed self-checking bench for perf_counter_bank (NUM_CH=5,
//            CNT_W=4, SCAN_DIV=3). Honours PERF_SATURATE_EN when defined.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_perf_counter_bank;

    localparam int NUM_CH   = 5;
    localparam int CNT_W    = 4;
    localparam int SEL_W    = 3;
    localparam int SCAN_DIV = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] events;
    logic              en;
    logic              clr;
    logic              snap;
    logic              auto_scan;
    logic [SEL_W-1:0]  sel;
    logic [CNT_W-1:0]  rd_data;
    logic [SEL_W-1:0]  rd_ch;
    logic [NUM_CH-1:0] ovf;
    logic              snap_valid;

    int errors = 0;
    int checks = 0;

    perf_counter_bank #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .SEL_W    (SEL_W),
        .SCAN_DIV (SCAN_DIV)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .events     (events),
        .en         (en),
        .clr        (clr),
        .snap       (snap),
        .auto_scan  (auto_scan),
        .sel        (sel),
        .rd_data    (rd_data),
        .rd_ch      (rd_ch),
        .ovf        (ovf),
        .snap_valid (snap_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; events = '0; en = 1'b0; clr = 1'b0; snap = 1'b0;
        auto_scan = 1'b0; sel = '0;
        tick();
        check_val("rst_rd_data", 32'(rd_data), 0);
        check_val("rst_rd_ch", 32'(rd_ch), 0);
        check_val("rst_ovf", 32'(ovf), 0);
        check_val("rst_snap_valid", 32'(snap_valid), 0);
        rst = 1'b0;

        // Ten events on channel 0
        en = 1'b1; events = 5'b00001;
        for (int k = 0; k < 10; k++) tick();
        events = '0;
        tick();
        check_val("count10", 32'(rd_data), 10);
        check_val("count10_ovf", 32'(ovf), 0);

        // Channel 1 to 7, then snap together with an event
        events = 5'b00010; sel = 3'd1;
        for (int k = 0; k < 7; k++) tick();
        snap = 1'b1;
        tick();
        snap = 1'b0; events = '0;
        check_val("snap_valid_set", 32'(snap_valid), 1);
        tick();
        check_val("shadow1", 32'(rd_data), 7);
        tick();
        check_val("shadow1_hold", 32'(rd_data), 7);
        sel = 3'd0;
        tick();
        check_val("shadow0", 32'(rd_data), 10);
        // Re-snap exposes the live value 8
        sel = 3'd1; snap = 1'b1;
        tick();
        snap = 1'b0;
        tick();
        check_val("resnap_live1", 32'(rd_data), 8);
        check_val("resnap_valid", 32'(snap_valid), 1);

        // clr + snap + event in one cycle
        clr = 1'b1; snap = 1'b1; events = 5'b00001; sel = 3'd0;
        tick();
        clr = 1'b0; snap = 1'b0; events = '0;
        check_val("prio_snap_valid", 32'(snap_valid), 0);
        check_val("prio_ovf", 32'(ovf), 0);
        tick();
        check_val("prio_cnt0", 32'(rd_data), 0);

        // Wrap / saturate on channel 2
        sel = 3'd2; events = 5'b00100;
        for (int k = 0; k < 15; k++) tick();
        check_val("ovf_before_16th", 32'(ovf), 0);
        tick();
        events = '0;
        check_val("ovf_after_16th", 32'(ovf), 32'b00100);
        tick();
`ifdef PERF_SATURATE_EN
        check_val("sat_cnt2", 32'(rd_data), 15);
`else
        check_val("wrap_cnt2", 32'(rd_data), 0);
`endif
        // Frozen counters
        en = 1'b0; events = 5'b00100;
        tick(); tick();
        events = '0; en = 1'b1;
`ifdef PERF_SATURATE_EN
        check_val("freeze_cnt2", 32'(rd_data), 15);
`else
        check_val("freeze_cnt2", 32'(rd_data), 0);
`endif
        check_val("ovf_sticky", 32'(ovf), 32'b00100);

        // Out-of-range select
        sel = 3'd6;
        tick();
        check_val("oor_rd_ch", 32'(rd_ch), 6);
        check_val("oor_rd_data", 32'(rd_data), 0);

        // Auto-scan sequence
        auto_scan = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            tick();
            check_val($sformatf("scan_rd_ch_%0d", k), 32'(rd_ch), 32'((k / SCAN_DIV) % NUM_CH));
        end
        auto_scan = 1'b0; sel = 3'd3;
        tick();
        tick();
        check_val("scan_exit_rd_ch", 32'(rd_ch), 3);

        // Reset mid-scan
        auto_scan = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        check_val("midscan_rst_rd_ch", 32'(rd_ch), 0);
        check_val("midscan_rst_rd_data", 32'(rd_data), 0);
        rst = 1'b0;
        tick();
        check_val("post_rst_manual", 32'(rd_ch), 3);
        tick();
        check_val("post_rst_scan0", 32'(rd_ch), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
